// File: rtl/order_delete_encoder_if.sv
// ---------------------------------------------------------------------------
// order_delete_encoder_if
//   Groups the record-input handshake and the beat-output stream of the
//   ITCH Order Delete encoder.
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where the producer's valid and the consumer's ready are both high.
//   The producer must not withdraw valid or change its payload until the
//   transfer completes. Ready may depend combinationally on the other side's
//   signals.
//     record side : startIn (valid) / inReady (ready)
//     beat side   : validOut (valid) / readyIn (ready)
//
//   Signals
//     startIn, timeStampIn, orderIDIn, orderBookIDIn, sideIn : record in
//     inReady                                                : record ready
//     dataOut, keepOut, lastOut, trackerOut, validOut        : beat out
//     readyIn                                                : beat ready
//
//   Modports
//     master : the environment (record producer + beat consumer)
//     slave  : the encoder
// ---------------------------------------------------------------------------
interface order_delete_encoder_if;
    logic        startIn;
    logic        inReady;
    logic [31:0] timeStampIn;
    logic [63:0] orderIDIn;
    logic [31:0] orderBookIDIn;
    logic [7:0]  sideIn;
    logic [63:0] dataOut;
    logic [7:0]  keepOut;
    logic        validOut;
    logic        readyIn;
    logic        lastOut;
    logic [5:0]  trackerOut;

    modport master (
        output startIn, timeStampIn, orderIDIn, orderBookIDIn, sideIn, readyIn,
        input  inReady, dataOut, keepOut, validOut, lastOut, trackerOut
    );

    modport slave (
        input  startIn, timeStampIn, orderIDIn, orderBookIDIn, sideIn, readyIn,
        output inReady, dataOut, keepOut, validOut, lastOut, trackerOut
    );
endinterface

// File: rtl/order_delete_encoder.sv
// ---------------------------------------------------------------------------
// order_delete_encoder
//   Takes one decoded ITCH Order Delete record and serialises it into the
//   18-byte big-endian wire format as three 64-bit beats:
//     W0: {type, ts[31:0], oid[63:40]}    keep FF  tracker 8
//     W1: {oid[39:0], obid[31:8]}         keep FF  tracker 16
//     W2: {obid[7:0], side, 48'h0}        keep C0  tracker 18  last
//   A new record may be accepted in the W2 cycle that hands off the last
//   beat, so sustained throughput is one message per three cycles.
//
//   Ports
//     clk      : clock, rising edge
//     rst      : asynchronous active-low reset
//     bus      : record in / beat out handshake (slave modport)
//     sideErr  : one-cycle pulse after accepting a side other than 'B'/'S'
//     msgCount : messages whose last beat was accepted (wraps)
//     dbgState : current FSM state (0 IDLE, 1 W0, 2 W1, 3 W2)
// ---------------------------------------------------------------------------
module order_delete_encoder #(
    parameter logic [7:0] MSG_TYPE = 8'h44,
    parameter int         CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    order_delete_encoder_if.slave   bus,
    output logic                    sideErr,
    output logic [CNT_W-1:0]        msgCount,
    output logic [1:0]              dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_ts;
    logic [63:0]        r_oid;
    logic [31:0]        r_obid;
    logic [7:0]         r_side;
    logic               r_side_err;
    logic [CNT_W-1:0]   r_msg_count;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_side_bad;
    logic               w_last_done;
    logic [63:0]        w_data;
    logic [7:0]         w_keep;
    logic               w_valid;
    logic               w_last;
    logic [5:0]         w_tracker;

    // Gated by rst so nothing is accepted while reset is held.
    assign w_in_ready  = rst && ((r_state == IDLE) || ((r_state == W2) && bus.readyIn));
    assign w_accept    = bus.startIn && w_in_ready;
    assign w_side_bad  = (bus.sideIn != 8'h42) && (bus.sideIn != 8'h53);
    assign w_last_done = (r_state == W2) && bus.readyIn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ts        <= '0;
            r_oid       <= '0;
            r_obid      <= '0;
            r_side      <= '0;
            r_side_err  <= 1'b0;
            r_msg_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_side_err <= w_accept && w_side_bad;
            if (w_accept) begin
                r_ts   <= bus.timeStampIn;
                r_oid  <= bus.orderIDIn;
                r_obid <= bus.orderBookIDIn;
                r_side <= bus.sideIn;
            end
            if (w_last_done) begin
                r_msg_count <= r_msg_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept)    w_next_state = W0;
            W0:   if (bus.readyIn) w_next_state = W1;
            W1:   if (bus.readyIn) w_next_state = W2;
            W2:   if (bus.readyIn) w_next_state = w_accept ? W0 : IDLE;
            default:               w_next_state = IDLE;
        endcase
    end

    // Beat outputs are a pure function of state and latched fields, so they
    // hold steady under backpressure and drop as soon as reset asserts.
    always_comb begin
        w_data    = 64'h0;
        w_keep    = 8'h00;
        w_valid   = 1'b0;
        w_last    = 1'b0;
        w_tracker = 6'd0;
        case (r_state)
            W0: begin
                w_data    = {MSG_TYPE, r_ts, r_oid[63:40]};
                w_keep    = 8'hFF;
                w_valid   = 1'b1;
                w_tracker = 6'd8;
            end
            W1: begin
                w_data    = {r_oid[39:0], r_obid[31:8]};
                w_keep    = 8'hFF;
                w_valid   = 1'b1;
                w_tracker = 6'd16;
            end
            W2: begin
                w_data    = {r_obid[7:0], r_side, 48'h0};
                w_keep    = 8'hC0;
                w_valid   = 1'b1;
                w_last    = 1'b1;
                w_tracker = 6'd18;
            end
            default: ;
        endcase
    end

    assign bus.inReady    = w_in_ready;
    assign bus.dataOut    = w_data;
    assign bus.keepOut    = w_keep;
    assign bus.validOut   = w_valid;
    assign bus.lastOut    = w_last;
    assign bus.trackerOut = w_tracker;
    assign sideErr        = r_side_err;
    assign msgCount       = r_msg_count;
    assign dbgState       = r_state;

endmodule

// File: doc/order_delete_encoder.md
Name: order_delete_encoder

Overview:
- Transmit-side counterpart of the ITCH Order Delete ('D') parser.
- Accepts one decoded Order Delete record (timestamp, order ID, orderbook ID, side) through a valid/ready handshake.
- Serialises the record into the 18-byte big-endian ITCH wire format as three 64-bit beats, with byte-keep and last markers.
- Sits between the order-management logic and the outbound ITCH stream packer. Used for loopback testing of the parser and for market-data replay.

Parameters:
- MSG_TYPE, 8'h44, message-type byte placed in byte 0 ('D').
- CNT_W, 16, width of the sent-message counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset). Deassertion is synchronised externally.
- startIn  in  1  input record valid.
- inReady  out  1  encoder can accept a record this cycle.
- timeStampIn  in  32  nanosecond timestamp.
- orderIDIn  in  64  order ID.
- orderBookIDIn  in  32  orderbook ID.
- sideIn  in  8  side byte: 'B' = 8'h42, 'S' = 8'h53.
- dataOut  out  64  output beat; byte 0 of the beat is on [63:56].
- keepOut  out  8  byte-valid mask; bit 7 corresponds to [63:56].
- validOut  out  1  dataOut/keepOut/lastOut are valid.
- readyIn  in  1  downstream accepts the beat.
- lastOut  out  1  final beat of the message.
- trackerOut  out  6  cumulative bytes emitted for the current message, including the present beat: 8, 16, 18.
- sideErr  out  1  one-cycle pulse when an accepted record has a side other than 8'h42 or 8'h53.
- msgCount  out  CNT_W  number of messages whose last beat was accepted; wraps.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to IDLE.
  - validOut, lastOut, sideErr = 0.
  - dataOut = 0, keepOut = 0, trackerOut = 0, msgCount = 0.
  - Latched fields cleared.
  - inReady = 0 while in reset.
  - A message in flight is discarded; no partial beat is emitted after reset releases.
- States: IDLE, W0, W1, W2. Output registers are driven from the state and the latched fields.
- Accept:
  - A record is taken when startIn && inReady at a clock edge.
  - inReady = (state == IDLE) || (state == W2 && readyIn).
  - All four fields are latched at that edge; later changes on the inputs do not affect the message.
- Beat layout and flags:
  - W0: dataOut = {MSG_TYPE, ts[31:0], oid[63:40]}; keepOut = 8'hFF; trackerOut = 8; lastOut = 0.
  - W1: dataOut = {oid[39:0], obid[31:8]}; keepOut = 8'hFF; trackerOut = 16; lastOut = 0.
  - W2: dataOut = {obid[7:0], side, 48'h0}; keepOut = 8'hC0; trackerOut = 18; lastOut = 1.
  - validOut = 1 in W0, W1 and W2.
- Latency: the first beat is valid in the cycle after the accept edge.
- Transitions:
  - IDLE -> W0 on accept.
  - W0 -> W1 and W1 -> W2 when readyIn = 1.
  - W2 with readyIn = 1: go to W0 if a new record is accepted in the same cycle (back-to-back, no bubble); otherwise go to IDLE.
  - readyIn = 0 in any Wx: hold state; dataOut, keepOut, lastOut and trackerOut stay stable (valid is never withdrawn).
- msgCount increments by 1 on each edge where state == W2 && readyIn. It wraps from 2^CNT_W-1 to 0.
- sideErr:
  - Pulses high for exactly one cycle, the cycle after an accept with an illegal side.
  - The message is still encoded unchanged.
- In IDLE: dataOut and keepOut hold 0, trackerOut = 0, validOut = 0.
- Throughput: 3 cycles per message at sustained readyIn = 1.

Test Plan:
- Basic encode: ts = 32'h11223344, oid = 64'h0102030405060708, obid = 32'hAABBCCDD, side = 8'h42, readyIn = 1.
  -> beats 64'h4411223344010203 (keep FF, tracker 8), 64'h0405060708AABBCC (keep FF, tracker 16), 64'hDD42000000000000 (keep C0, last, tracker 18). msgCount = 1.
- Back-to-back: startIn held high with two records (second side = 8'h53).
  -> 6 consecutive valid beats with no idle cycle. inReady = 1 only in IDLE and in W2 && readyIn. msgCount = 2.
- Backpressure: readyIn = 0 for 3 cycles during W1.
  -> dataOut stays 64'h0405060708AABBCC and validOut stays 1; W2 follows 1 cycle after readyIn rises.
- Illegal side: side = 8'h58 accepted.
  -> sideErr high for exactly 1 cycle; third beat = {obid[7:0], 8'h58, 48'h0}.
- Reset mid-message: rst = 0 asserted during W1 (between clock edges).
  -> validOut = 0 immediately, before the next edge. After release: IDLE, inReady = 1, msgCount = 0, no stray beats.
- Counter wrap: CNT_W = 2, send 5 messages.
  -> msgCount sequence 1, 2, 3, 0, 1.
